// File: rtl/reg_bank_param.sv
// reg_bank_param: DEPTH x WIDTH register bank with one write port, two
// registered read ports and a sequenced bulk-clear engine.
// Optional build macro: REG_BANK_BYPASS_EN enables write-through forwarding
// from the write/clear path to both read ports.
module reg_bank_param #(
    parameter int WIDTH  = 8,
    parameter int ADDR_W = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    output logic              wr_ready,
    input  logic [ADDR_W-1:0] rd_addr_a,
    output logic [WIDTH-1:0]  rd_data_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic [WIDTH-1:0]  rd_data_b,
    input  logic              clr_req,
    output logic              clr_busy,
    output logic              clr_done
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] IDX_LAST = '1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] idx;
    logic [WIDTH-1:0]  regs [DEPTH];

    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [WIDTH-1:0]  wdata;

    // Single storage write path: the clear engine owns it in CLEAR, otherwise an accepted port write.
    always_comb begin
        we    = 1'b0;
        waddr = '0;
        wdata = '0;
        if (state == CLEAR) begin
            we    = 1'b1;
            waddr = idx;
            wdata = '0;
        end else if (wr_en && wr_ready) begin
            we    = 1'b1;
            waddr = wr_addr;
            wdata = wr_data;
        end
    end

    // Register storage.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else if (we) begin
            regs[waddr] <= wdata;
        end
    end

    // Registered read ports, optionally forwarding the value being written this cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data_a <= '0;
            rd_data_b <= '0;
        end else begin
`ifdef REG_BANK_BYPASS_EN
            rd_data_a <= (we && (waddr == rd_addr_a)) ? wdata : regs[rd_addr_a];
            rd_data_b <= (we && (waddr == rd_addr_b)) ? wdata : regs[rd_addr_b];
`else
            rd_data_a <= regs[rd_addr_a];
            rd_data_b <= regs[rd_addr_b];
`endif
        end
    end

    // Clear sequencer; handshake outputs are registered alongside the state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            idx      <= '0;
            clr_busy <= 1'b0;
            clr_done <= 1'b0;
            wr_ready <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    clr_done <= 1'b0;
                    if (clr_req) begin
                        state    <= CLEAR;
                        idx      <= '0;
                        clr_busy <= 1'b1;
                        wr_ready <= 1'b0;
                    end
                end
                CLEAR: begin
                    if (idx == IDX_LAST) begin
                        state    <= DONE;
                        idx      <= '0;
                        clr_done <= 1'b1;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                DONE: begin
                    state    <= IDLE;
                    clr_busy <= 1'b0;
                    clr_done <= 1'b0;
                    wr_ready <= 1'b1;
                end
                default: begin
                    state    <= IDLE;
                    idx      <= '0;
                    clr_busy <= 1'b0;
                    clr_done <= 1'b0;
                    wr_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reg_bank_param.sv
// Self-checking bench for reg_bank_param (WIDTH=8, ADDR_W=2).
module tb_reg_bank_param;

    localparam int DEPTH = 4;
`ifdef REG_BANK_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic       clk;
    logic       reset;
    logic       wr_en;
    logic [1:0] wr_addr;
    logic [7:0] wr_data;
    logic       wr_ready;
    logic [1:0] rd_addr_a;
    logic [7:0] rd_data_a;
    logic [1:0] rd_addr_b;
    logic [7:0] rd_data_b;
    logic       clr_req;
    logic       clr_busy;
    logic       clr_done;

    reg_bank_param #(.WIDTH(8), .ADDR_W(2)) dut (
        .clk       (clk),
        .reset     (reset),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .wr_ready  (wr_ready),
        .rd_addr_a (rd_addr_a),
        .rd_data_a (rd_data_a),
        .rd_addr_b (rd_addr_b),
        .rd_data_b (rd_data_b),
        .clr_req   (clr_req),
        .clr_busy  (clr_busy),
        .clr_done  (clr_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model: register contents plus "cycles since clear started"
    // (0 = idle, 1..DEPTH = clearing register cnt-1, DEPTH+1 = done cycle).
    logic [7:0] mem [DEPTH];
    int         cnt;
    logic [7:0] m_a, m_b;
    logic       m_busy, m_done, m_ready;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cycle(input logic rst, input logic we, input logic [1:0] wa, input logic [7:0] wd,
                         input logic [1:0] ra, input logic [1:0] rb, input logic cr);
        logic [7:0] pre [DEPTH];
        reset = rst; wr_en = we; wr_addr = wa; wr_data = wd;
        rd_addr_a = ra; rd_addr_b = rb; clr_req = cr;
        pre = mem;
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] = 8'h00;
            m_a = 8'h00; m_b = 8'h00; cnt = 0;
        end else begin
            if (cnt == 0 && we) mem[wa] = wd;
            if (cnt >= 1 && cnt <= DEPTH) mem[cnt-1] = 8'h00;
            m_a = BYP ? mem[ra] : pre[ra];
            m_b = BYP ? mem[rb] : pre[rb];
            if (cnt == 0) cnt = cr ? 1 : 0;
            else if (cnt == DEPTH + 1) cnt = 0;
            else cnt = cnt + 1;
        end
        m_busy  = (cnt != 0);
        m_done  = (cnt == DEPTH + 1);
        m_ready = !m_busy;
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic       rst, we;
        logic [1:0] wa;
        logic [7:0] wd;
        logic [1:0] ra, rb;
        logic       cr;
        logic [7:0] ea, eb;
        logic       erdy, ebsy, edn;
    } vec_t;

    vec_t vt [7];

    initial begin
        int busy_n, rdylo_n, done_n, done_at;
        bit seen;
        logic [1:0] ra, rb;

        for (int i = 0; i < DEPTH; i++) mem[i] = 8'h00;
        cnt = 0; m_a = 0; m_b = 0; m_busy = 0; m_done = 0; m_ready = 1;
        reset = 1; wr_en = 0; wr_addr = 0; wr_data = 0;
        rd_addr_a = 0; rd_addr_b = 0; clr_req = 0;

        // Directed table: reset, basic writes/reads, same-cycle read-after-write.
        vt[0] = '{1, 0, 2'd0, 8'h00, 2'd0, 2'd0, 0, 8'h00, 8'h00, 1, 0, 0};
        vt[1] = '{0, 1, 2'd0, 8'hA5, 2'd0, 2'd3, 0, BYP ? 8'hA5 : 8'h00, 8'h00, 1, 0, 0};
        vt[2] = '{0, 1, 2'd3, 8'h3C, 2'd0, 2'd3, 0, 8'hA5, BYP ? 8'h3C : 8'h00, 1, 0, 0};
        vt[3] = '{0, 0, 2'd0, 8'h00, 2'd0, 2'd3, 0, 8'hA5, 8'h3C, 1, 0, 0};
        vt[4] = '{0, 0, 2'd0, 8'h00, 2'd1, 2'd2, 0, 8'h00, 8'h00, 1, 0, 0};
        vt[5] = '{0, 1, 2'd2, 8'h11, 2'd2, 2'd0, 0, BYP ? 8'h11 : 8'h00, 8'hA5, 1, 0, 0};
        vt[6] = '{0, 0, 2'd0, 8'h00, 2'd2, 2'd2, 0, 8'h11, 8'h11, 1, 0, 0};
        for (int i = 0; i < 7; i++) begin
            cycle(vt[i].rst, vt[i].we, vt[i].wa, vt[i].wd, vt[i].ra, vt[i].rb, vt[i].cr);
            chk($sformatf("vec%0d_rd_a", i), rd_data_a, vt[i].ea);
            chk($sformatf("vec%0d_rd_b", i), rd_data_b, vt[i].eb);
            chk($sformatf("vec%0d_ready", i), {7'd0, wr_ready}, {7'd0, vt[i].erdy});
            chk($sformatf("vec%0d_busy", i), {7'd0, clr_busy}, {7'd0, vt[i].ebsy});
            chk($sformatf("vec%0d_done", i), {7'd0, clr_done}, {7'd0, vt[i].edn});
        end

        // Full clear with a dropped write to reg1 during CLEAR.
        for (int i = 0; i < DEPTH; i++) cycle(0, 1, 2'(i), 8'hFF, 0, 0, 0);
        busy_n = 0; rdylo_n = 0; done_n = 0; done_at = -1;
        for (int s = 0; s < 6; s++) begin
            cycle(0, s == 2, 2'd1, 8'h77, 0, 0, s == 0);
            if (clr_busy) busy_n++;
            if (!wr_ready) rdylo_n++;
            if (clr_done) begin done_n++; done_at = s; end
        end
        chk("clr_busy_cycles", 8'(busy_n), 8'd5);
        chk("clr_ready_low_cycles", 8'(rdylo_n), 8'd5);
        chk("clr_done_count", 8'(done_n), 8'd1);
        chk("clr_done_position", 8'(done_at), 8'd4);
        for (int i = 0; i < DEPTH; i++) begin
            cycle(0, 0, 0, 0, 2'(i), 2'(3 - i), 0);
            chk($sformatf("after_clr_a%0d", i), rd_data_a, 8'h00);
            chk($sformatf("after_clr_b%0d", 3 - i), rd_data_b, 8'h00);
        end

        // Write accepted in the same cycle as clr_req, then wiped.
        cycle(0, 1, 2'd3, 8'h42, 2'd3, 2'd3, 1);
        cycle(0, 0, 0, 0, 2'd3, 2'd3, 0);
        chk("req_write_accepted", rd_data_a, 8'h42);
        seen = 0;
        for (int s = 0; s < 10 && !seen; s++) begin
            cycle(0, 0, 0, 0, 2'd3, 2'd3, 0);
            if (clr_done) seen = 1;
        end
        chk("req_done_seen", {7'd0, seen}, 8'd1);
        cycle(0, 0, 0, 0, 2'd3, 2'd3, 0);
        chk("req_write_cleared", rd_data_a, 8'h00);

        // Reset in the second CLEAR cycle aborts the sequence.
        for (int i = 0; i < DEPTH; i++) cycle(0, 1, 2'(i), 8'(8'h30 + i), 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 0, 1);
        cycle(0, 0, 0, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0, 0, 0);
        chk("abort_busy", {7'd0, clr_busy}, 8'd0);
        chk("abort_ready", {7'd0, wr_ready}, 8'd1);
        done_n = 0;
        for (int i = 0; i < DEPTH + 2; i++) begin
            cycle(0, 0, 0, 0, 2'(i), 2'(i + 1), 0);
            if (clr_done) done_n++;
            chk($sformatf("abort_reg%0d", i % DEPTH), rd_data_a, 8'h00);
        end
        chk("abort_no_done", 8'(done_n), 8'd0);

        // Randomized traffic against the reference model.
        for (int i = 0; i < 400; i++) begin
            ra = 2'($urandom_range(0, 3));
            rb = 2'($urandom_range(0, 3));
            cycle($urandom_range(0, 59) == 0, $urandom_range(0, 1) == 1, 2'($urandom_range(0, 3)),
                  8'($urandom), ra, rb, $urandom_range(0, 7) == 0);
            chk("rnd_rd_a", rd_data_a, m_a);
            chk("rnd_rd_b", rd_data_b, m_b);
            chk("rnd_ready", {7'd0, wr_ready}, {7'd0, m_ready});
            chk("rnd_busy", {7'd0, clr_busy}, {7'd0, m_busy});
            chk("rnd_done", {7'd0, clr_done}, {7'd0, m_done});
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
